// File: rtl/csr_commit_queue_if.sv
// Handshake bundle between the writeback stage, the CSR commit queue and the
// commit consumer. The queue sits on the slave modport; whoever drives
// commits and consumes beats sits on the master modport.
interface csr_commit_queue_if #(
    parameter int XLEN = 32
);
    logic            commit_valid;
    logic            csr_wen;
    logic [XLEN-1:0] waddr;
    logic [XLEN-1:0] wdata;
    logic            exception_wen;
    logic [XLEN-1:0] mcause_in;
    logic [XLEN-1:0] pc_wb;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic            out_kind;
    logic [XLEN-1:0] out_addr;
    logic [XLEN-1:0] out_data;

    modport master (
        output commit_valid, csr_wen, waddr, wdata, exception_wen, mcause_in, pc_wb, out_ready,
        input  in_ready, out_valid, out_kind, out_addr, out_data
    );

    modport slave (
        input  commit_valid, csr_wen, waddr, wdata, exception_wen, mcause_in, pc_wb, out_ready,
        output in_ready, out_valid, out_kind, out_addr, out_data
    );
endinterface

// File: rtl/csr_commit_queue.sv
// CSR commit queue: captures up to two events per retiring instruction
// (CSR write first, then exception) into a small register FIFO and replays
// them in program order as a first-word-fall-through valid/ready stream.
// Events that do not fit are dropped and latch a sticky overflow flag.
module csr_commit_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    csr_commit_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 2 * XLEN + 1;

    logic [EW-1:0] entries [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_plus1;
    logic          e0;
    logic          e1;
    logic [1:0]    n_req;
    logic [1:0]    n_wr;
    logic [CW-1:0] free;
    logic          deq;
    logic [EW-1:0] wr_first;
    logic [EW-1:0] wr_second;
    logic [EW-1:0] head;

    // Work out which events exist this cycle and how many fit in the space
    // free at the start of the cycle; a same-cycle dequeue does not help.
    always_comb begin
        e0         = bus.commit_valid & bus.csr_wen;
        e1         = bus.commit_valid & bus.exception_wen;
        n_req      = {1'b0, e0} + {1'b0, e1};
        free       = CW'(DEPTH) - count;
        n_wr       = n_req;
        if (free < CW'(n_req)) begin
            n_wr = free[1:0];
        end
        wptr_plus1 = wptr + PW'(1);
        wr_first   = e0 ? {1'b0, bus.waddr, bus.wdata} : {1'b1, bus.mcause_in, bus.pc_wb};
        wr_second  = {1'b1, bus.mcause_in, bus.pc_wb};
        deq        = (count != '0) & bus.out_ready;
        head       = entries[rptr];
    end

    assign bus.in_ready  = (free >= CW'(2));
    assign bus.out_valid = (count != '0);
    assign {bus.out_kind, bus.out_addr, bus.out_data} = bus.out_valid ? head : '0;

    // Pointer, occupancy and sticky-overflow bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            wptr  <= wptr + PW'(n_wr);
            count <= count + CW'(n_wr) - CW'(deq);
            if (deq) begin
                rptr <= rptr + PW'(1);
            end
            if (n_wr != n_req) begin
                err_overflow <= 1'b1;
            end
        end
    end

    // Entry storage; the first accepted event goes to the tail, the second
    // to the slot after it (wrapping to index 0 from the last slot).
    always_ff @(posedge clock) begin
        if (n_wr != 2'd0) begin
            entries[wptr] <= wr_first;
        end
        if (n_wr == 2'd2) begin
            entries[wptr_plus1] <= wr_second;
        end
    end
endmodule

// File: tb/tb_csr_commit_queue.sv
// Bench for csr_commit_queue: directed commits push hand-computed beats into
// a scoreboard queue; an independent monitor pops and compares each beat the
// DUT hands over, while the main sequence checks occupancy and flags.
module tb_csr_commit_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 8;

    logic clock;
    logic reset;
    logic [$clog2(DEPTH):0] count;
    logic err_overflow;

    int checks = 0;
    int errors = 0;
    logic [2*XLEN:0] sb [$];

    csr_commit_queue_if #(.XLEN(XLEN)) bus ();

    csr_commit_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .count        (count),
        .err_overflow (err_overflow)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [2*XLEN:0] actual,
                               input logic [2*XLEN:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic cv, input logic cw, input logic [XLEN-1:0] addr,
                                 input logic [XLEN-1:0] data, input logic ew,
                                 input logic [XLEN-1:0] mc, input logic [XLEN-1:0] pc,
                                 input logic keep0, input logic keep1);
        bus.commit_valid  = cv;
        bus.csr_wen       = cw;
        bus.waddr         = addr;
        bus.wdata         = data;
        bus.exception_wen = ew;
        bus.mcause_in     = mc;
        bus.pc_wb         = pc;
        if (cv && cw && keep0) sb.push_back({1'b0, addr, data});
        if (cv && ew && keep1) sb.push_back({1'b1, mc, pc});
        @(posedge clock);
        #1;
        bus.commit_valid  = 1'b0;
        bus.csr_wen       = 1'b0;
        bus.exception_wen = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: every accepted beat must match the oldest expected event.
    initial begin
        logic [2*XLEN:0] exp_beat;
        forever begin
            @(negedge clock);
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL beat_unexpected: got 0x%0h expected no beat",
                             {bus.out_kind, bus.out_addr, bus.out_data});
                end else begin
                    exp_beat = sb.pop_front();
                    checkOutput("beat", {bus.out_kind, bus.out_addr, bus.out_data}, exp_beat);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        reset             = 1'b1;
        bus.commit_valid  = 1'b0;
        bus.csr_wen       = 1'b0;
        bus.exception_wen = 1'b0;
        bus.waddr         = '0;
        bus.wdata         = '0;
        bus.mcause_in     = '0;
        bus.pc_wb         = '0;
        bus.out_ready     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        checkOutput("rst_count", 65'(count), 0);
        checkOutput("rst_valid", 65'(bus.out_valid), 0);
        checkOutput("rst_in_ready", 65'(bus.in_ready), 1);
        checkOutput("rst_err", 65'(err_overflow), 0);
        checkOutput("rst_outputs", {bus.out_kind, bus.out_addr, bus.out_data}, 0);

        // Single CSR write, one-cycle latency, then empty again.
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h300, 32'h1888, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        checkOutput("t1_valid", 65'(bus.out_valid), 1);
        checkOutput("t1_count", 65'(count), 1);
        step(1);
        checkOutput("t1_valid_after", 65'(bus.out_valid), 0);
        checkOutput("t1_count_after", 65'(count), 0);

        // Combined CSR write + exception: two beats, CSR first.
        applyStimulus(1'b1, 1'b1, 32'h341, 32'h8000_0010, 1'b1, 32'hB, 32'h8000_0010, 1'b1, 1'b1);
        checkOutput("t2_count", 65'(count), 2);
        step(2);
        checkOutput("t2_count_after", 65'(count), 0);
        checkOutput("t2_idle_outputs", {bus.out_kind, bus.out_addr, bus.out_data}, 0);

        // Backpressure: fill to 8 with doubles, tail wraps through index 0.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h340 + i, 32'hA000 + i, 1'b1, i + 1,
                          32'h8000_0100 + 4 * i, 1'b1, 1'b1);
        end
        checkOutput("t3_count6", 65'(count), 6);
        checkOutput("t3_in_ready6", 65'(bus.in_ready), 1);
        checkOutput("t3_head_addr", 65'(bus.out_addr), 65'h340);
        applyStimulus(1'b1, 1'b1, 32'h343, 32'hA003, 1'b1, 32'h4, 32'h8000_010C, 1'b1, 1'b1);
        checkOutput("t3_count8", 65'(count), 8);
        checkOutput("t3_in_ready8", 65'(bus.in_ready), 0);
        step(1);
        checkOutput("t3_head_stable", {bus.out_kind, bus.out_addr, bus.out_data},
                    {1'b0, 32'h340, 32'hA000});
        bus.out_ready = 1'b1;
        step(8);
        checkOutput("t3_drained", 65'(count), 0);

        // Overflow with one free slot: E0 kept, E1 dropped, flag sticks.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h700 + i, 32'hB000 + i, 1'b1, 32'h10 + i,
                          32'h8000_0400 + 4 * i, 1'b1, 1'b1);
        end
        applyStimulus(1'b1, 1'b1, 32'h7F0, 32'h55, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        checkOutput("t4_count7", 65'(count), 7);
        checkOutput("t4_in_ready7", 65'(bus.in_ready), 0);
        checkOutput("t4_err_before", 65'(err_overflow), 0);
        applyStimulus(1'b1, 1'b1, 32'h7F1, 32'h66, 1'b1, 32'hC, 32'h8000_0200, 1'b1, 1'b0);
        checkOutput("t4_count8", 65'(count), 8);
        checkOutput("t4_err_set", 65'(err_overflow), 1);
        bus.out_ready = 1'b1;
        step(8);
        checkOutput("t4_drained", 65'(count), 0);
        checkOutput("t4_err_sticky", 65'(err_overflow), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checkOutput("t4_err_cleared", 65'(err_overflow), 0);

        // Commits carrying no events never set the flag, even when full.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h800 + i, 32'hC000 + i, 1'b1, 32'h20 + i,
                          32'h8000_0500 + 4 * i, 1'b1, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 32'h900, 32'h1, 1'b0, 32'h1, 32'h1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h901, 32'h2, 1'b1, 32'h2, 32'h2, 1'b1, 1'b1);
        checkOutput("t4b_count", 65'(count), 8);
        checkOutput("t4b_err", 65'(err_overflow), 0);
        bus.out_ready = 1'b1;
        step(8);
        checkOutput("t4b_drained", 65'(count), 0);

        // Simultaneous enqueue and dequeue.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h500, 32'h11, 1'b1, 32'h2, 32'h8000_0300, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h502, 32'h22, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        checkOutput("t5_count3", 65'(count), 3);
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h503, 32'h33, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        checkOutput("t5_count_single", 65'(count), 3);
        checkOutput("t5_head_advanced", {bus.out_kind, bus.out_addr, bus.out_data},
                    {1'b1, 32'h2, 32'h8000_0300});
        applyStimulus(1'b1, 1'b1, 32'h504, 32'h44, 1'b1, 32'h3, 32'h8000_0304, 1'b1, 1'b1);
        checkOutput("t5_count_double", 65'(count), 4);
        step(4);
        checkOutput("t5_drained", 65'(count), 0);

        // Asynchronous reset mid-drain, after a drop-all overflow.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h600 + i, 32'hD000 + i, 1'b1, 32'h30 + i,
                          32'h8000_0600 + 4 * i, 1'b1, 1'b1);
        end
        applyStimulus(1'b1, 1'b1, 32'h6FF, 32'h77, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("t6_err_dropall", 65'(err_overflow), 1);
        checkOutput("t6_count8", 65'(count), 8);
        bus.out_ready = 1'b1;
        step(3);
        checkOutput("t6_count5", 65'(count), 5);
        bus.out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_async_count", 65'(count), 0);
        checkOutput("t6_async_valid", 65'(bus.out_valid), 0);
        checkOutput("t6_async_err", 65'(err_overflow), 0);
        checkOutput("t6_async_outputs", {bus.out_kind, bus.out_addr, bus.out_data}, 0);
        sb.delete();
        #2;
        reset = 1'b0;
        step(1);

        // Queue works normally after the reset.
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h7A0, 32'h99, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        checkOutput("t6_post_valid", 65'(bus.out_valid), 1);
        step(1);
        checkOutput("t6_post_count", 65'(count), 0);

        checkOutput("sb_empty", 65'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
